// File: rtl/game_pkg.sv
// game_pkg: shared FSM states, one-hot level codes and level-to-length lookup for the memory game
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [2:0] LVL_1 = 3'b001;
    localparam logic [2:0] LVL_2 = 3'b010;
    localparam logic [2:0] LVL_3 = 3'b100;

    // Pattern length for a level; 0 marks a level code that is not one of the three one-hot values
    function automatic int level_to_len(input logic [2:0] lvl, input int l1, input int l2, input int l3);
        return (lvl == LVL_1) ? l1 : (lvl == LVL_2) ? l2 : (lvl == LVL_3) ? l3 : 0;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: per-button rising-edge detector; load masks edges and tracks the current levels
module btn_edge_detect #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] btn,
    output logic [N-1:0] edges,
    output logic         multi
);

    logic [N-1:0] prev;

    // Previous button levels; refreshed every cycle so a button held while loading never looks new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= btn;
    end

    assign edges = load ? '0 : (btn & ~prev);
    assign multi = |(edges & (edges - 1'b1));

endmodule

// File: rtl/round_manager.sv
// round_manager: per-round controller for the memory game (fetch, play, collect, score, gap)
module round_manager
    import game_pkg::*;
#(
    parameter int N_BTN         = 8,
    parameter int IDX_W         = 3,
    parameter int MAX_LEN       = 16,
    parameter int LEN_LV1       = 4,
    parameter int LEN_LV2       = 8,
    parameter int LEN_LV3       = 16,
    parameter int NUM_ROUNDS    = 5,
    parameter int SHOW_TICKS    = 2,
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 20,
    parameter int SCORE_W       = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tick,
    input  logic                            start,
    input  logic                            abort,
    input  logic [2:0]                      level,
    output logic                            pat_req,
    input  logic                            pat_valid,
    input  logic [MAX_LEN*IDX_W-1:0]        pattern_flat,
    input  logic [N_BTN-1:0]                btn,
    output logic [N_BTN-1:0]                led,
    output logic                            busy,
    output logic                            in_input,
    output logic [$clog2(NUM_ROUNDS+1)-1:0] round_cnt,
    output logic [SCORE_W-1:0]              score,
    output logic                            round_done,
    output logic                            game_done,
    output logic                            err_level
);

    localparam int STEP_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int RC_W   = $clog2(NUM_ROUNDS + 1);
    localparam int TK_W   = $clog2(SHOW_TICKS + GAP_TICKS + TIMEOUT_TICKS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t                   state, state_d;
    logic [MAX_LEN*IDX_W-1:0] pattern, pattern_d;
    logic [STEP_W-1:0]        len_m1, len_m1_d, step, step_d;
    logic [TK_W-1:0]          tick_cnt, tick_d;
    logic [RC_W-1:0]          round_d;
    logic [SCORE_W-1:0]       score_d;
    logic                     round_done_d, err_d, to_gap, multi;
    logic [N_BTN-1:0]         edges, exp_oh;
    logic [IDX_W-1:0]         cur;
    int                       lvl_len;

    btn_edge_detect #(.N(N_BTN)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state != S_INPUT),
        .btn   (btn),
        .edges (edges),
        .multi (multi)
    );

    assign cur    = pattern[int'(step)*IDX_W +: IDX_W];
    assign exp_oh = N_BTN'(1) << cur;

    assign pat_req   = (state == S_LOAD);
    assign busy      = !(state == S_IDLE || state == S_DONE);
    assign in_input  = (state == S_INPUT);
    assign game_done = (state == S_DONE);
    assign led       = (state == S_SHOW_ON) ? exp_oh : (state == S_INPUT) ? btn : '0;

    // Next state and counter updates; abort overrides everything but keeps score and round_cnt
    always_comb begin
        state_d      = state;
        pattern_d    = pattern;
        len_m1_d     = len_m1;
        step_d       = step;
        tick_d       = tick_cnt;
        round_d      = round_cnt;
        score_d      = score;
        round_done_d = 1'b0;
        err_d        = 1'b0;
        to_gap       = 1'b0;
        lvl_len      = level_to_len(level, LEN_LV1, LEN_LV2, LEN_LV3);
        if (abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            tick_d  = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    if (lvl_len == 0) err_d = 1'b1;
                    else begin
                        state_d  = S_LOAD;
                        len_m1_d = STEP_W'(lvl_len - 1);
                        step_d   = '0;
                        tick_d   = '0;
                        round_d  = '0;
                        score_d  = '0;
                    end
                end
                S_LOAD: if (pat_valid) begin
                    state_d   = S_SHOW_ON;
                    pattern_d = pattern_flat;
                    step_d    = '0;
                    tick_d    = '0;
                end
                S_SHOW_ON: if (tick) begin
                    state_d = (tick_cnt == TK_W'(SHOW_TICKS - 1)) ? S_SHOW_OFF : S_SHOW_ON;
                    tick_d  = (tick_cnt == TK_W'(SHOW_TICKS - 1)) ? '0 : tick_cnt + 1'b1;
                end
                S_SHOW_OFF: if (tick) begin
                    state_d = (step == len_m1) ? S_INPUT : S_SHOW_ON;
                    step_d  = (step == len_m1) ? '0 : step + 1'b1;
                    tick_d  = '0;
                end
                S_INPUT: if (|edges) begin
                    tick_d = '0;
                    if (!multi && edges == exp_oh) begin
                        score_d = (score == SCORE_MAX) ? score : score + 1'b1;
                        step_d  = step + 1'b1;
                        to_gap  = (step == len_m1);
                    end else to_gap = 1'b1;
                end else if (tick) begin
                    to_gap = (tick_cnt == TK_W'(TIMEOUT_TICKS - 1));
                    tick_d = tick_cnt + 1'b1;
                end
                S_GAP: if (tick) begin
                    if (tick_cnt == TK_W'(GAP_TICKS - 1)) begin
                        state_d = (round_cnt < RC_W'(NUM_ROUNDS)) ? S_LOAD : S_DONE;
                        tick_d  = '0;
                    end else tick_d = tick_cnt + 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (to_gap) begin
                state_d      = S_GAP;
                step_d       = '0;
                tick_d       = '0;
                round_d      = round_cnt + 1'b1;
                round_done_d = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Datapath registers: latched pattern/length, counters, score and the two pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern    <= '0;
            len_m1     <= '0;
            step       <= '0;
            tick_cnt   <= '0;
            round_cnt  <= '0;
            score      <= '0;
            round_done <= 1'b0;
            err_level  <= 1'b0;
        end else begin
            pattern    <= pattern_d;
            len_m1     <= len_m1_d;
            step       <= step_d;
            tick_cnt   <= tick_d;
            round_cnt  <= round_d;
            score      <= score_d;
            round_done <= round_done_d;
            err_level  <= err_d;
        end
    end

endmodule

// File: tb/tb_round_manager.sv
// tb_round_manager: randomized games checked against a round-level reference model
module tb_round_manager;

    localparam int N_BTN      = 8;
    localparam int IDX_W      = 3;
    localparam int MAX_LEN    = 16;
    localparam int NUM_ROUNDS = 5;
    localparam int SCORE_W    = 7;
    localparam int SHOW_T     = 2;
    localparam int GAP_T      = 4;
    localparam int TO_T       = 20;
    localparam int SCORE_MAX  = 127;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     tick = 1'b0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     pat_valid = 1'b0;
    logic [2:0]               level = 3'b000;
    logic [MAX_LEN*IDX_W-1:0] pattern_flat = '0;
    logic [N_BTN-1:0]         btn = '0;
    logic [N_BTN-1:0]         led;
    logic                     pat_req, busy, in_input, round_done, game_done, err_level;
    logic [2:0]               round_cnt;
    logic [SCORE_W-1:0]       score;

    int n_chk = 0;
    int n_fail = 0;
    int exp_score = 0;
    int exp_rounds = 0;
    bit tk;
    logic [IDX_W-1:0] pat [MAX_LEN];

    round_manager dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .start        (start),
        .abort        (abort),
        .level        (level),
        .pat_req      (pat_req),
        .pat_valid    (pat_valid),
        .pattern_flat (pattern_flat),
        .btn          (btn),
        .led          (led),
        .busy         (busy),
        .in_input     (in_input),
        .round_cnt    (round_cnt),
        .score        (score),
        .round_done   (round_done),
        .game_done    (game_done),
        .err_level    (err_level)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N_BTN-1:0] oh(input int i);
        logic [N_BTN-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int lvl_len(input logic [2:0] l);
        case (l)
            3'b001:  return 4;
            3'b010:  return 8;
            3'b100:  return 16;
            default: return 0;
        endcase
    endfunction

    // tk is the tick presented to the state observed just before this call
    task automatic step();
        tk = ($urandom_range(0, 1) == 1);
        tick = tk;
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode: 0 all correct, 1 wrong press, 2 two edges at once, 3 timeout, 4 abort mid-input
    task automatic play_round(input int len, input int mode, input bit fixed, output bit aborted);
        int guard, w, flashes, lit_t, dark_t, qt, gt;
        logic [N_BTN-1:0] prev_led;
        aborted = 1'b0;
        guard = 0;
        while (!pat_req && guard < 20) begin step(); guard++; end
        chk("pat_req_up", pat_req, 1);
        repeat ($urandom_range(0, 3)) begin step(); chk("pat_req_hold", pat_req, 1); end
        for (int k = 0; k < MAX_LEN; k++) begin
            if (!(fixed && k < 4)) pat[k] = IDX_W'($urandom_range(0, N_BTN - 1));
            pattern_flat[k*IDX_W +: IDX_W] = pat[k];
        end
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        pattern_flat = (MAX_LEN*IDX_W)'({$urandom, $urandom});
        chk("pat_req_drop", pat_req, 0);
        flashes = 0; lit_t = 0; dark_t = 0; guard = 0; prev_led = '0;
        while (!in_input && guard < 1000) begin
            if (led != '0) begin
                if (prev_led == '0) begin
                    if (flashes > 0) chk("dark_ticks", dark_t, 1);
                    flashes++;
                    lit_t = 0;
                end
                chk("show_led", led, oh((flashes <= MAX_LEN) ? int'(pat[flashes-1]) : 0));
                btn = ($urandom_range(0, 3) == 0) ? oh($urandom_range(0, N_BTN - 1)) : '0;
            end else begin
                if (prev_led != '0) begin
                    chk("lit_ticks", lit_t, SHOW_T);
                    dark_t = 0;
                end
                btn = '0;
            end
            prev_led = led;
            step();
            guard++;
            if (prev_led != '0) lit_t += int'(tk);
            else dark_t += int'(tk);
        end
        chk("flash_count", flashes, len);
        chk("last_dark_ticks", dark_t, 1);
        w = (mode == 0) ? len : $urandom_range(0, len - 1);
        qt = 0;
        for (int p = 0; p < w; p++) begin
            btn = oh(pat[p]);
            step();
            if (exp_score < SCORE_MAX) exp_score++;
            chk("score_press", score, exp_score);
            if (p == len - 1) break;
            chk("echo_led", led, oh(pat[p]));
            chk("stay_input", in_input, 1);
            btn = '0;
            qt = 0;
            repeat ($urandom_range(1, 3)) begin step(); qt += int'(tk); end
        end
        if (mode == 1 || mode == 2) begin
            btn = oh((int'(pat[w]) + $urandom_range(1, N_BTN - 1)) % N_BTN);
            if (mode == 2) btn = btn | oh(pat[w]);
            step();
            chk("score_wrong", score, exp_score);
        end else if (mode == 3) begin
            guard = 0;
            while (in_input && guard < 200) begin step(); qt += int'(tk); guard++; end
            chk("timeout_ticks", qt, TO_T);
        end else if (mode == 4) begin
            btn = oh(pat[w]);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_led", led, 0);
            chk("abort_pat_req", pat_req, 0);
            chk("abort_in_input", in_input, 0);
            chk("abort_score", score, exp_score);
            chk("abort_rounds", round_cnt, exp_rounds);
            btn = '0;
            aborted = 1'b1;
            return;
        end
        chk("round_done", round_done, 1);
        chk("gap_no_input", in_input, 0);
        exp_rounds++;
        chk("round_cnt", round_cnt, exp_rounds);
        chk("score_round", score, exp_score);
        gt = 0; guard = 0;
        while (!pat_req && !game_done && guard < 100) begin
            if (guard > 0) chk("round_done_pulse", round_done, 0);
            chk("gap_led", led, 0);
            btn = ($urandom_range(0, 2) == 0) ? oh($urandom_range(0, N_BTN - 1)) : '0;
            step();
            gt += int'(tk);
            guard++;
        end
        btn = '0;
        chk("gap_ticks", gt, GAP_T);
        chk("score_kept", score, exp_score);
        chk("game_done_flag", game_done, exp_rounds == NUM_ROUNDS);
    endtask

    task automatic run_game(input logic [2:0] lv, input int abort_round, input bit fixed);
        int len, mode;
        bit ab;
        len = lvl_len(lv);
        level = lv;
        start = 1'b1;
        step();
        start = 1'b0;
        level = 3'($urandom);
        exp_score = 0;
        exp_rounds = 0;
        chk("start_pat_req", pat_req, 1);
        chk("start_busy", busy, 1);
        chk("start_score", score, 0);
        chk("start_rounds", round_cnt, 0);
        for (int r = 0; r < NUM_ROUNDS; r++) begin
            mode = (r == abort_round) ? 4 : (fixed && r == 0) ? 0 : int'($urandom_range(0, 3));
            play_round(len, mode, fixed && r == 0, ab);
            if (ab) return;
        end
        chk("done_busy", busy, 0);
        chk("done_rounds", round_cnt, NUM_ROUNDS);
        step();
        chk("done_hold", game_done, 1);
        chk("done_score_hold", score, exp_score);
    endtask

    initial begin
        logic [2:0] bad [4];
        int guard;
        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_pat_req", pat_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_input", in_input, 0);
        chk("rst_round_cnt", round_cnt, 0);
        chk("rst_score", score, 0);
        chk("rst_round_done", round_done, 0);
        chk("rst_game_done", game_done, 0);
        chk("rst_err_level", err_level, 0);
        rst_n = 1'b1;
        step();

        bad[0] = 3'b011; bad[1] = 3'b000; bad[2] = 3'b111; bad[3] = 3'b110;
        for (int i = 0; i < 4; i++) begin
            level = bad[i];
            start = 1'b1;
            step();
            start = 1'b0;
            chk("err_pulse", err_level, 1);
            chk("err_idle_busy", busy, 0);
            chk("err_no_req", pat_req, 0);
            step();
            chk("err_pulse_end", err_level, 0);
        end

        pat[0] = 3'd3; pat[1] = 3'd0; pat[2] = 3'd5; pat[3] = 3'd1;
        run_game(3'b001, -1, 1'b1);

        abort = 1'b1;
        start = 1'b1;
        level = 3'b010;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("prio_game_done", game_done, 0);
        chk("prio_busy", busy, 0);
        chk("prio_pat_req", pat_req, 0);
        chk("prio_score", score, exp_score);
        chk("prio_rounds", round_cnt, NUM_ROUNDS);

        for (int g = 0; g < 7; g++) begin
            bad[0] = 3'(1 << $urandom_range(0, 2));
            run_game(bad[0], ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1, 1'b0);
        end

        level = 3'b010;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) pattern_flat[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, N_BTN - 1));
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        guard = 0;
        while (led == '0 && guard < 50) begin step(); guard++; end
        chk("show_lit_before_rst", led != '0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", led, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pat_req", pat_req, 0);
        chk("arst_score", score, 0);
        chk("arst_round_cnt", round_cnt, 0);
        chk("arst_game_done", game_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
